// File: rtl/event_encoder_16_to_4_pkg.sv
// rtl/event_encoder_16_to_4_pkg.sv - shared constants, types and FSM encoding for the event encoder
package decoder_pkg;

    localparam int N_LINES = 16;
    localparam int CODE_W  = 4;

    typedef logic [CODE_W-1:0]  code_t;
    typedef logic [N_LINES-1:0] lines_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } enc_state_t;

    // One-hot line vector for a code; used both to clear a selected line and to test the presented one
    function automatic lines_t onehot(input code_t c);
        return lines_t'(1) << c;
    endfunction

endpackage

// File: rtl/event_encoder_16_to_4_if.sv
// rtl/event_encoder_16_to_4_if.sv - request/handshake/status bundle between event sources, encoder and consumer
interface event_encoder_16_to_4_if;
    import decoder_pkg::*;

    logic   ena;
    lines_t req;
    logic   out_valid;
    logic   out_ready;
    code_t  out_code;
    lines_t pending;
    logic   merged;

    modport master (
        output ena,
        output req,
        output out_ready,
        input  out_valid,
        input  out_code,
        input  pending,
        input  merged
    );

    modport slave (
        input  ena,
        input  req,
        input  out_ready,
        output out_valid,
        output out_code,
        output pending,
        output merged
    );

endinterface

// File: rtl/event_encoder_16_to_4_prio.sv
// rtl/event_encoder_16_to_4_prio.sv - combinational lowest-set-index priority encoder
module priority_encoder_16_to_4
    import decoder_pkg::*;
(
    input  lines_t lines,
    output code_t  code,
    output logic   any
);

    // Scan from the top down so the lowest set index is the last to write and wins
    always_comb begin
        code = '0;
        for (int i = N_LINES - 1; i >= 0; i--) begin
            if (lines[i]) begin
                code = code_t'(i);
            end
        end
    end

    assign any = |lines;

endmodule

// File: rtl/event_encoder_16_to_4.sv
// rtl/event_encoder_16_to_4.sv - sticky event capture with one-code-per-event valid/ready output
module event_encoder_16_to_4
    import decoder_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    event_encoder_16_to_4_if.slave  bus
);

    enc_state_t state_q;
    enc_state_t state_d;
    lines_t     pending_q;
    code_t      code_q;
    logic       merged_q;

    lines_t     set;
    lines_t     clr;
    lines_t     presented;
    code_t      sel_code;
    logic       any;
    logic       accept;
    logic       load;
    logic       merged_d;

    priority_encoder_16_to_4 u_prio (
        .lines (pending_q),
        .code  (sel_code),
        .any   (any)
    );

    assign set    = bus.req & {N_LINES{bus.ena}};
    assign accept = (state_q == HOLD) && bus.out_ready;

    // A presented code only absorbs a new event while it is still waiting to be taken
    assign presented = ((state_q == HOLD) && !bus.out_ready) ? onehot(code_q) : '0;
    assign merged_d  = |(set & (pending_q | presented));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: stay in HOLD while there is more to present after an accept
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (any) state_d = HOLD;
            HOLD: if (accept && !any) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: when to load a new code and which pending line it consumes
    always_comb begin
        load = 1'b0;
        case (state_q)
            IDLE: load = any;
            HOLD: load = accept && any;
            default: load = 1'b0;
        endcase
        clr = load ? onehot(sel_code) : '0;
    end

    // Pending vector, output code and merge pulse; set is applied after clear so a fresh event re-pends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            code_q    <= '0;
            merged_q  <= 1'b0;
        end else begin
            pending_q <= (pending_q & ~clr) | set;
            merged_q  <= merged_d;
            if (load) begin
                code_q <= sel_code;
            end
        end
    end

    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_code  = code_q;
    assign bus.pending   = pending_q;
    assign bus.merged    = merged_q;

endmodule
